conv_line_extend: RTL and testbench



---
 rtl/conv_line_extend.sv | 219 +++++++++++++++++++++
 tb/tb_conv_line_extend.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_extend.sv
// conv_line_extend: wraps every raster line with PAD extension pixels on each
// side so downstream convolution windows never see an image border.
// Extension pixels are zeros (ZERO_PAD) or copies of the edge pixel (REPLICATE).
// Optional build macro: CONV_LINE_EXTEND_STATS_EN adds o_line_cnt, a 16-bit
// wrapping count of completed output lines.

package cfg_pkg;
  localparam string EXTEND_STRATEGY = "REPLICATE";
endpackage

module conv_line_extend #(
  parameter int    W               = 8,
  parameter int    PAD             = 1,
  parameter string EXTEND_STRATEGY = cfg_pkg::EXTEND_STRATEGY
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_vld,
  output logic         i_rdy,
  input  logic [W-1:0] i_dat,
  input  logic         i_sol,
  input  logic         i_eol,
  output logic         o_vld,
  input  logic         o_rdy,
  output logic [W-1:0] o_dat,
  output logic         o_sol,
  output logic         o_eol,
  output logic         o_ext,
`ifdef CONV_LINE_EXTEND_STATS_EN
  output logic [15:0]  o_line_cnt,
`endif
  output logic         o_err
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; a producer holds data and flags stable while valid && !ready, and
  // ready may depend combinationally on the consumer's ready (never on valid).

  localparam int            CW       = $clog2(PAD + 1);
  localparam bit            REPL     = (EXTEND_STRATEGY == "REPLICATE");
  localparam logic [CW-1:0] CNT_LAST = CW'(PAD - 1);

  if (!(EXTEND_STRATEGY == "ZERO_PAD" || EXTEND_STRATEGY == "REPLICATE")) begin : g_bad_strategy
    $error("conv_line_extend: EXTEND_STRATEGY must be ZERO_PAD or REPLICATE");
  end
  if (PAD < 1 || PAD > 4) begin : g_bad_pad
    $error("conv_line_extend: PAD must be in 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for a start-of-line beat
    S_PRE  = 2'd1,  // emitting left extension, then the held first pixel
    S_BODY = 2'd2,  // passing image pixels straight through
    S_POST = 2'd3   // emitting right extension after the last pixel
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          hold_eol_q, hold_eol_d;
  logic          o_vld_q, o_vld_d;
  logic [W-1:0]  o_dat_q, o_dat_d;
  logic          o_sol_q, o_sol_d;
  logic          o_eol_q, o_eol_d;
  logic          o_ext_q, o_ext_d;
  logic          o_err_q, o_err_d;
  logic          load_en;
  logic          in_rdy;
  logic          in_acc;

  // Pad value: the given edge pixel when replicating, zero otherwise.
  function automatic logic [W-1:0] pad_px(input logic [W-1:0] px);
    return REPL ? px : '0;
  endfunction

  assign load_en = !o_vld_q || o_rdy;
  assign in_rdy  = load_en && (state_q == S_IDLE || state_q == S_BODY);
  assign in_acc  = i_vld && in_rdy;

  // Next-state and next-output computation for the line-extension FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_eol_d = hold_eol_q;
    o_vld_d    = o_vld_q;
    o_dat_d    = o_dat_q;
    o_sol_d    = o_sol_q;
    o_eol_d    = o_eol_q;
    o_ext_d    = o_ext_q;
    o_err_d    = o_err_q;
    if (load_en) begin
      // Output slot is free this cycle; it empties unless a branch fills it.
      o_vld_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_acc) begin
            if (i_sol) begin
              hold_d     = i_dat;
              hold_eol_d = i_eol;
              cnt_d      = '0;
              state_d    = S_PRE;
              o_vld_d    = 1'b1;
              o_dat_d    = pad_px(i_dat);
              o_sol_d    = 1'b1;
              o_eol_d    = 1'b0;
              o_ext_d    = 1'b1;
            end else begin
              // Mid-line data with no line open: discard and flag.
              o_err_d = 1'b1;
            end
          end
        end
        S_PRE: begin
          o_vld_d = 1'b1;
          o_sol_d = 1'b0;
          o_eol_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            o_dat_d = hold_q;
            o_ext_d = 1'b0;
            cnt_d   = '0;
            state_d = hold_eol_q ? S_POST : S_BODY;
          end else begin
            o_dat_d = pad_px(hold_q);
            o_ext_d = 1'b1;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        S_BODY: begin
          if (in_acc) begin
            o_vld_d = 1'b1;
            o_dat_d = i_dat;
            o_sol_d = 1'b0;
            o_eol_d = 1'b0;
            o_ext_d = 1'b0;
            if (i_sol) begin
              o_err_d = 1'b1;
            end
            if (i_eol) begin
              hold_d  = i_dat;
              cnt_d   = '0;
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          o_vld_d = 1'b1;
          o_dat_d = pad_px(hold_q);
          o_sol_d = 1'b0;
          o_ext_d = 1'b1;
          o_eol_d = (cnt_q == CNT_LAST);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef CONV_LINE_EXTEND_STATS_EN
  logic [15:0] line_cnt_q, line_cnt_d;

  // Count completed output lines (the eol beat leaving the output register).
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (o_vld_q && o_rdy && o_eol_q) begin
      line_cnt_d = line_cnt_q + 16'd1;
    end
  end

  assign o_line_cnt = line_cnt_q;
`endif

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_eol_q <= 1'b0;
      o_vld_q    <= 1'b0;
      o_dat_q    <= '0;
      o_sol_q    <= 1'b0;
      o_eol_q    <= 1'b0;
      o_ext_q    <= 1'b0;
      o_err_q    <= 1'b0;
`ifdef CONV_LINE_EXTEND_STATS_EN
      line_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_eol_q <= hold_eol_d;
      o_vld_q    <= o_vld_d;
      o_dat_q    <= o_dat_d;
      o_sol_q    <= o_sol_d;
      o_eol_q    <= o_eol_d;
      o_ext_q    <= o_ext_d;
      o_err_q    <= o_err_d;
`ifdef CONV_LINE_EXTEND_STATS_EN
      line_cnt_q <= line_cnt_d;
`endif
    end
  end

  assign i_rdy = in_rdy;
  assign o_vld = o_vld_q;
  assign o_dat = o_dat_q;
  assign o_sol = o_sol_q;
  assign o_eol = o_eol_q;
  assign o_ext = o_ext_q;
  assign o_err = o_err_q;

endmodule

// File: tb/tb_conv_line_extend.sv
// tb_conv_line_extend: directed, table-driven bench for conv_line_extend.
// Instance A: PAD=2 REPLICATE, instance B: PAD=2 ZERO_PAD (A and B share all
// inputs), instance C: PAD=1 REPLICATE with its own inputs.
// Optional build macro: CONV_LINE_EXTEND_STATS_EN (checks o_line_cnt).

module tb_conv_line_extend;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       i_vld = 1'b0, i_sol = 1'b0, i_eol = 1'b0, o_rdy = 1'b1;
  logic [7:0] i_dat = '0;
  logic       a_irdy, a_vld, a_sol, a_eol, a_ext, a_err;
  logic [7:0] a_dat;
  logic       b_irdy, b_vld, b_sol, b_eol, b_ext, b_err;
  logic [7:0] b_dat;
  logic       c_vld = 1'b0, c_sol = 1'b0, c_eol = 1'b0, c_ordy = 1'b1;
  logic [7:0] c_dat = '0;
  logic       c_irdy, c_ovld, c_osol, c_oeol, c_oext, c_err;
  logic [7:0] c_odat;
`ifdef CONV_LINE_EXTEND_STATS_EN
  logic [15:0] a_lc, b_lc, c_lc;
`endif

  conv_line_extend #(.W(8), .PAD(2), .EXTEND_STRATEGY("REPLICATE")) u_a (
    .clk(clk), .arst_n(arst_n), .i_vld(i_vld), .i_rdy(a_irdy), .i_dat(i_dat),
    .i_sol(i_sol), .i_eol(i_eol), .o_vld(a_vld), .o_rdy(o_rdy), .o_dat(a_dat),
    .o_sol(a_sol), .o_eol(a_eol), .o_ext(a_ext),
`ifdef CONV_LINE_EXTEND_STATS_EN
    .o_line_cnt(a_lc),
`endif
    .o_err(a_err));

  conv_line_extend #(.W(8), .PAD(2), .EXTEND_STRATEGY("ZERO_PAD")) u_b (
    .clk(clk), .arst_n(arst_n), .i_vld(i_vld), .i_rdy(b_irdy), .i_dat(i_dat),
    .i_sol(i_sol), .i_eol(i_eol), .o_vld(b_vld), .o_rdy(o_rdy), .o_dat(b_dat),
    .o_sol(b_sol), .o_eol(b_eol), .o_ext(b_ext),
`ifdef CONV_LINE_EXTEND_STATS_EN
    .o_line_cnt(b_lc),
`endif
    .o_err(b_err));

  conv_line_extend #(.W(8), .PAD(1), .EXTEND_STRATEGY("REPLICATE")) u_c (
    .clk(clk), .arst_n(arst_n), .i_vld(c_vld), .i_rdy(c_irdy), .i_dat(c_dat),
    .i_sol(c_sol), .i_eol(c_eol), .o_vld(c_ovld), .o_rdy(c_ordy), .o_dat(c_odat),
    .o_sol(c_osol), .o_eol(c_oeol), .o_ext(c_oext),
`ifdef CONV_LINE_EXTEND_STATS_EN
    .o_line_cnt(c_lc),
`endif
    .o_err(c_err));

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- output ready driver ----------------
  int         rdy_mode = 0;      // 0: always ready, 1: pattern 1,0,0,1, 2: never
  int         cyc = 0;
  logic [0:3] rdy_pat = 4'b1001;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       o_rdy = 1'b1;
      1:       o_rdy = rdy_pat[cyc % 4];
      default: o_rdy = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  // Entry = {sol, eol, ext, dat}.
  logic [10:0] exp_a_q[$];
  logic [10:0] exp_b_q[$];
  logic        sb_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [21:0] prev_out;
  logic [21:0] cur_out;
  logic [10:0] e_a, e_b;

  always @(negedge clk) begin
    cur_out = {a_sol, a_eol, a_ext, a_dat, b_sol, b_eol, b_ext, b_dat};
    if (!sb_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_vld", {a_vld, b_vld}, 2'b11);
        check("stall_hold_data", cur_out, prev_out);
      end
      if (a_vld && o_rdy) begin
        if (exp_a_q.size() == 0) begin
          check("extra_beat_a", {a_sol, a_eol, a_ext, a_dat}, 11'h7ff);
        end else begin
          e_a = exp_a_q.pop_front();
          check("beat_a_sol_eol_ext_dat", {a_sol, a_eol, a_ext, a_dat}, e_a);
        end
      end
      if (b_vld && o_rdy) begin
        if (exp_b_q.size() == 0) begin
          check("extra_beat_b", {b_sol, b_eol, b_ext, b_dat}, 11'h7ff);
        end else begin
          e_b = exp_b_q.pop_front();
          check("beat_b_sol_eol_ext_dat", {b_sol, b_eol, b_ext, b_dat}, e_b);
        end
      end
      stall_prev = a_vld && !o_rdy;
      prev_out   = cur_out;
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    logic took;
    took  = 1'b0;
    i_vld = 1'b1; i_dat = d; i_sol = s; i_eol = e;
    for (int k = 0; k < 200 && !took; k++) begin
      @(negedge clk);
      took = a_irdy;
      @(posedge clk);
      #1;
    end
    i_vld = 1'b0; i_sol = 1'b0; i_eol = 1'b0;
    if (!took) check("send_beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_left_a", exp_a_q.size(), 0);
    check("drain_left_b", exp_b_q.size(), 0);
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  task automatic push_exp(input int n, input logic [0:11][7:0] rep,
                          input logic [0:11][7:0] zro, input logic [0:11] ext);
    for (int j = 0; j < n; j++) begin
      exp_a_q.push_back({j == 0, j == n - 1, ext[j], rep[j]});
      exp_b_q.push_back({j == 0, j == n - 1, ext[j], zro[j]});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               n_in;
    logic [0:7][7:0]  px;
    int               rdy_mode;
    int               n_out;
    logic [0:11][7:0] exp_rep;
    logic [0:11][7:0] exp_zero;
    logic [0:11]      exp_ext;
  } vec_t;

  vec_t tbl[4];

  // C (PAD=1) single-pixel sequence: {vld,dat,sol,eol,ext} and {irdy,err}.
  logic [11:0] c_exp_out[4];
  logic [1:0]  c_exp_ctl[4];

  // ---------------- main test ----------------
  initial begin
    tbl[0].n_in = 3; tbl[0].rdy_mode = 0; tbl[0].n_out = 7;
    tbl[0].px       = {8'd10, 8'd20, 8'd30, 40'd0};
    tbl[0].exp_rep  = {8'd10, 8'd10, 8'd10, 8'd20, 8'd30, 8'd30, 8'd30, 40'd0};
    tbl[0].exp_zero = {8'd0, 8'd0, 8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 40'd0};
    tbl[0].exp_ext  = {7'b1100011, 5'b0};

    tbl[1].n_in = 8; tbl[1].rdy_mode = 1; tbl[1].n_out = 12;
    tbl[1].px       = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[1].exp_rep  = {8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd8, 8'd8};
    tbl[1].exp_zero = {8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0};
    tbl[1].exp_ext  = 12'b110000000011;

    tbl[2].n_in = 2; tbl[2].rdy_mode = 1; tbl[2].n_out = 6;
    tbl[2].px       = {8'd200, 8'd5, 48'd0};
    tbl[2].exp_rep  = {8'd200, 8'd200, 8'd200, 8'd5, 8'd5, 8'd5, 48'd0};
    tbl[2].exp_zero = {8'd0, 8'd0, 8'd200, 8'd5, 8'd0, 8'd0, 48'd0};
    tbl[2].exp_ext  = {6'b110011, 6'b0};

    tbl[3].n_in = 1; tbl[3].rdy_mode = 0; tbl[3].n_out = 5;
    tbl[3].px       = {8'd77, 56'd0};
    tbl[3].exp_rep  = {8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 56'd0};
    tbl[3].exp_zero = {8'd0, 8'd0, 8'd77, 8'd0, 8'd0, 56'd0};
    tbl[3].exp_ext  = {5'b11011, 7'b0};

    c_exp_out[0] = {1'b1, 8'd7, 1'b1, 1'b0, 1'b1}; c_exp_ctl[0] = 2'b00;
    c_exp_out[1] = {1'b1, 8'd7, 1'b0, 1'b0, 1'b0}; c_exp_ctl[1] = 2'b00;
    c_exp_out[2] = {1'b1, 8'd7, 1'b0, 1'b1, 1'b1}; c_exp_ctl[2] = 2'b10;
    c_exp_out[3] = {1'b0, 8'd0, 1'b0, 1'b0, 1'b0}; c_exp_ctl[3] = 2'b10;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a_outs", {a_vld, a_sol, a_eol, a_ext, a_dat, a_err}, 0);
    check("reset_b_outs", {b_vld, b_sol, b_eol, b_ext, b_dat, b_err}, 0);
    check("reset_c_outs", {c_ovld, c_osol, c_oeol, c_oext, c_odat, c_err}, 0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    sb_en  = 1'b1;
    @(negedge clk);
    check("idle_i_rdy", {a_irdy, b_irdy, c_irdy}, 3'b111);
`ifdef CONV_LINE_EXTEND_STATS_EN
    check("reset_line_cnt", a_lc, 0);
`endif
    @(posedge clk);
    #1;

    // Table-driven lines on A and B.
    for (int v = 0; v < 4; v++) begin
      rdy_mode = tbl[v].rdy_mode;
      push_exp(tbl[v].n_out, tbl[v].exp_rep, tbl[v].exp_zero, tbl[v].exp_ext);
      for (int i = 0; i < tbl[v].n_in; i++) begin
        send_beat(tbl[v].px[i], i == 0, i == tbl[v].n_in - 1);
      end
      drain();
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;
    end
    check("no_err_after_clean_lines", {a_err, b_err}, 2'b00);
`ifdef CONV_LINE_EXTEND_STATS_EN
    check("line_cnt_after_table", a_lc, 4);
`endif

    // PAD=1 single pixel on C: latency, i_rdy low in PRE/POST, no error.
    c_vld = 1'b1; c_dat = 8'd7; c_sol = 1'b1; c_eol = 1'b1;
    @(negedge clk);
    check("c_irdy_before_accept", c_irdy, 1'b1);
    @(posedge clk);
    #1;
    c_vld = 1'b0; c_sol = 1'b0; c_eol = 1'b0; c_dat = 8'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("c_ctl_irdy_err", {c_irdy, c_err}, c_exp_ctl[k]);
      if (k < 3) check("c_beat_vld_dat_sol_eol_ext", {c_ovld, c_odat, c_osol, c_oeol, c_oext}, c_exp_out[k]);
      else       check("c_vld_drops", c_ovld, 1'b0);
      @(posedge clk);
      #1;
    end

    // Stray beat in IDLE is dropped and flags the sticky error.
    send_beat(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    check("stray_no_output", {a_vld, b_vld}, 2'b00);
    check("stray_sets_err", {a_err, b_err}, 2'b11);
    @(posedge clk);
    #1;
    push_exp(5, {8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 56'd0}, {8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 56'd0},
             {5'b11011, 7'b0});
    send_beat(8'd4, 1'b1, 1'b1);
    drain();
    check("err_sticky", {a_err, b_err}, 2'b11);
    repeat (2) @(posedge clk);
    #1;

    // Reset while in the right-extension phase, then a fresh line.
    sb_en = 1'b0;
    send_beat(8'd9, 1'b1, 1'b0);
    send_beat(8'd9, 1'b0, 1'b0);
    send_beat(8'd9, 1'b0, 1'b1);
    rdy_mode = 2;
    o_rdy    = 1'b0;
    arst_n   = 1'b0;
    @(negedge clk);
    check("midline_reset_a", {a_vld, a_sol, a_eol, a_ext, a_dat, a_err}, 0);
    check("midline_reset_b", {b_vld, b_sol, b_eol, b_ext, b_dat, b_err}, 0);
    @(posedge clk);
    #1;
    arst_n   = 1'b1;
    rdy_mode = 0;
    o_rdy    = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    sb_en = 1'b1;
    push_exp(6, {8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 48'd0}, {8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 48'd0},
             {6'b110011, 6'b0});
    send_beat(8'd3, 1'b1, 1'b0);
    send_beat(8'd4, 1'b0, 1'b1);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("no_err_after_reset", {a_err, b_err}, 2'b00);
`ifdef CONV_LINE_EXTEND_STATS_EN
    check("line_cnt_after_reset", a_lc, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
